regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, range 1..15: number of consecutive waiting cycles before the debug requester forces a pipeline hold.
REQ-002 clock  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 wb_dstE, wb_dstM  in  4 each  pipeline writeback destinations; 4'hF means no write.
REQ-005 wb_valE, wb_valM  in  64 each  pipeline writeback data.
REQ-006 dbg_valid  in  1  debug write request.
REQ-007 dbg_reg  in  4  debug target register, 0..14; 4'hF is a no-op write.
REQ-008 dbg_data  in  64  debug write data.
REQ-009 dbg_ready  out  1  debug write accepted this cycle when dbg_valid is also 1.
REQ-010 rf_dstE, rf_dstM  out  4 each  to register-file write ports.
REQ-011 rf_valE, rf_valM  out  64 each  to register-file write data.
REQ-012 pipe_hold  out  1  pipeline SHALL drive wb_dstE = wb_dstM = 4'hF in any cycle where this is 1.
REQ-013 clear_done  out  1  register file initialised; stays 1 until next reset.

Function
REQ-014 FSM states: CLEAR, IDLE, HOLD; a 4-bit clear index; a 4-bit starve counter.
REQ-015 CLEAR: rf_dstE = idx, rf_dstM = idx+1 (4'hF when idx = 14), both data 0; idx steps by 2 each cycle from 0; 8 cycles total; after the idx = 14 cycle go to IDLE and set clear_done to 1.
REQ-016 In CLEAR: pipe_hold = 1, dbg_ready = 0, wb_* ignored.
REQ-017 IDLE/HOLD: rf_dstE/rf_valE = wb_dstE/wb_valE unconditionally; the pipeline is never dropped.
REQ-018 Grant condition: wb_dstM = 4'hF and wb_dstE != dbg_reg; dbg_ready = grant and state is IDLE or HOLD (combinational).
REQ-019 Transfer = dbg_valid and dbg_ready: rf_dstM = dbg_reg, rf_valM = dbg_data, written on that clock edge; otherwise rf_dstM/rf_valM = wb_dstM/wb_valM.
REQ-020 dbg_valid, dbg_reg and dbg_data SHALL be held stable by the requester until transfer.
REQ-021 Starve counter: increments, saturating at 15, each IDLE cycle with dbg_valid = 1 and no transfer; clears on transfer or when dbg_valid = 0.
REQ-022 IDLE -> HOLD on the edge where the counter reaches STARVE_LIMIT; pipe_hold = 1 in HOLD.
REQ-023 HOLD -> IDLE on the edge after a transfer, or when dbg_valid drops; the counter clears in both cases.
REQ-024 In HOLD, if the pipeline violates REQ-012, the pipeline write wins per REQ-017/REQ-018 and the debug request keeps waiting.
REQ-025 dbg_reg = 4'hF with a transfer completes the handshake; the register file does not write.

Reset
REQ-026 On reset: state = CLEAR, idx = 0, starve counter = 0, clear_done = 0, pipe_hold = 1, dbg_ready = 0, rf_dstE = 0, rf_dstM = 1, rf_val* = 0.
REQ-027 Reset asserted mid-CLEAR, mid-HOLD or during a debug transfer restarts the clear from idx 0; an in-flight debug request is not transferred until after CLEAR.

Configuration
REQ-028 Macro RF_CLEAR_ON_RESET_EN defined: clear sequencer built as above.
REQ-029 RF_CLEAR_ON_RESET_EN undefined: no CLEAR state or index; reset enters IDLE with clear_done = 1, pipe_hold = 0, rf_dst* = 4'hF during reset; all other behaviour unchanged.

Verification
REQ-030 Reset for 1 cycle, then release -> regs 0..14 are written 0 over 8 cycles (pairs 0/1 … 12/13, then 14/F); clear_done = 1 in cycle 9; pipe_hold = 0 from cycle 9.
REQ-031 IDLE, wb_dstE = 3, wb_dstM = F, dbg_valid = 1, dbg_reg = 5, dbg_data = 0xDEAD -> dbg_ready = 1 the same cycle; reg3 gets valE, reg5 = 0xDEAD next cycle.
REQ-032 dbg_reg = 2 with wb_dstE = 2 every cycle, STARVE_LIMIT = 8 -> no grant for 8 cycles, then HOLD with pipe_hold = 1; once the pipeline issues F/F, the transfer occurs; pipe_hold = 0 on the following cycle.
REQ-033 wb_dstM = 7 with dbg_valid = 1 -> dbg_ready = 0, rf_dstM = 7, rf_valM = wb_valM; starve counter increments.
REQ-034 Reset asserted at clear idx = 6 -> clear restarts at idx 0; 8 further cycles to clear_done.
REQ-035 Macro undefined, reset -> clear_done = 1 and a debug write is accepted on the first post-reset cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter_if
//  Description : Bus bundle for the register-file write arbiter.
//                Carries the pipeline writeback ports (wb_*), the debug write
//                request/handshake (dbg_*), the arbitrated register-file
//                write ports (rf_*) and the pipe_hold / clear_done status.
//                slave  : arbiter side (consumes wb_*/dbg_* requests,
//                         drives rf_*, dbg_ready, pipe_hold, clear_done)
//                master : environment side (pipeline + debug requester +
//                         register file)
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_wr_arbiter_if;
    logic [3:0]  wb_dstE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valE;
    logic [63:0] wb_valM;

    logic        dbg_valid;
    logic [3:0]  dbg_reg;
    logic [63:0] dbg_data;
    logic        dbg_ready;

    logic [3:0]  rf_dstE;
    logic [3:0]  rf_dstM;
    logic [63:0] rf_valE;
    logic [63:0] rf_valM;

    logic        pipe_hold;
    logic        clear_done;

    modport slave (
        input  wb_dstE, wb_dstM, wb_valE, wb_valM,
        input  dbg_valid, dbg_reg, dbg_data,
        output dbg_ready,
        output rf_dstE, rf_dstM, rf_valE, rf_valM,
        output pipe_hold, clear_done
    );

    modport master (
        output wb_dstE, wb_dstM, wb_valE, wb_valM,
        output dbg_valid, dbg_reg, dbg_data,
        input  dbg_ready,
        input  rf_dstE, rf_dstM, rf_valE, rf_valM,
        input  pipe_hold, clear_done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Shares the two register-file write ports between the
//                pipeline writeback stage and a debug write requester.
//                The pipeline E port always passes through; the debug
//                request borrows the M port in cycles where the pipeline
//                leaves it idle and does not target the same register on E.
//                A debug request that waits STARVE_LIMIT consecutive cycles
//                raises pipe_hold so the pipeline frees the ports.
//                Optional register-file clear after reset is built when the
//                macro RF_CLEAR_ON_RESET_EN is defined.
//  Ports       : clock, reset        - single clock, sync active-high reset
//                bus (slave modport) - wb_* in, dbg_* handshake, rf_* out,
//                                      pipe_hold, clear_done
//  Parameters  : STARVE_LIMIT (1..15) - waiting cycles before pipe_hold
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    regfile_wr_arbiter_if.slave bus
);

    localparam logic [3:0]  c_NO_WRITE = 4'hF;
    localparam logic [3:0]  c_CNT_MAX  = 4'hF;
    localparam logic [3:0]  c_LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [63:0] c_ZERO     = 64'd0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

`ifdef RF_CLEAR_ON_RESET_EN
    localparam state_t     c_RESET_STATE = ST_CLEAR;
    localparam logic [3:0] c_LAST_IDX    = 4'd14;
`else
    localparam state_t     c_RESET_STATE = ST_IDLE;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_nxt;
    logic [3:0]  w_starve_inc;

`ifdef RF_CLEAR_ON_RESET_EN
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic        r_clear_done;
    logic        w_clear_done_nxt;
`endif

    logic        w_grant;
    logic        w_active;
    logic        w_ready;
    logic        w_xfer;
    logic [3:0]  w_rf_dstE;
    logic [3:0]  w_rf_dstM;
    logic [63:0] w_rf_valE;
    logic [63:0] w_rf_valM;
    logic        w_pipe_hold;

    // The M port is free for the debug write only when the pipeline leaves it
    // idle and the E write does not collide with the debug target.
    assign w_grant  = (bus.wb_dstM == c_NO_WRITE) && (bus.wb_dstE != bus.dbg_reg);
    assign w_active = (r_state == ST_IDLE) || (r_state == ST_HOLD);
    // Reset gates the handshake so a request in flight across reset is never
    // accepted in the reset cycle itself.
    assign w_ready  = w_grant && w_active && !reset;
    assign w_xfer   = bus.dbg_valid && w_ready;

    assign w_starve_inc = (r_starve == c_CNT_MAX) ? c_CNT_MAX : (r_starve + 4'd1);

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
`ifdef RF_CLEAR_ON_RESET_EN
        w_idx_nxt        = r_idx;
        w_clear_done_nxt = r_clear_done;
`endif
        w_rf_dstE   = bus.wb_dstE;
        w_rf_valE   = bus.wb_valE;
        w_rf_dstM   = w_xfer ? bus.dbg_reg  : bus.wb_dstM;
        w_rf_valM   = w_xfer ? bus.dbg_data : bus.wb_valM;
        w_pipe_hold = 1'b0;

        case (r_state)
`ifdef RF_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                // Two registers per cycle: idx on E, idx+1 on M. Register 15
                // does not exist, so the final pair writes 14 only.
                w_rf_dstE   = r_idx;
                w_rf_dstM   = (r_idx == c_LAST_IDX) ? c_NO_WRITE : (r_idx + 4'd1);
                w_rf_valE   = c_ZERO;
                w_rf_valM   = c_ZERO;
                w_pipe_hold = 1'b1;
                w_idx_nxt   = r_idx + 4'd2;
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt      = ST_IDLE;
                    w_idx_nxt        = 4'd0;
                    w_clear_done_nxt = 1'b1;
                end
            end
`endif
            ST_IDLE: begin
                if (w_xfer || !bus.dbg_valid) begin
                    w_starve_nxt = 4'd0;
                end else begin
                    w_starve_nxt = w_starve_inc;
                    if (w_starve_inc == c_LIMIT) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                w_pipe_hold = 1'b1;
                // The counter is frozen while holding; a non-compliant
                // pipeline simply keeps the request waiting.
                if (w_xfer || !bus.dbg_valid) begin
                    w_state_nxt  = ST_IDLE;
                    w_starve_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt  = c_RESET_STATE;
                w_starve_nxt = 4'd0;
            end
        endcase

        // Outputs show their reset values for as long as reset is held.
        if (reset) begin
`ifdef RF_CLEAR_ON_RESET_EN
            w_rf_dstE   = 4'd0;
            w_rf_dstM   = 4'd1;
            w_pipe_hold = 1'b1;
`else
            w_rf_dstE   = c_NO_WRITE;
            w_rf_dstM   = c_NO_WRITE;
            w_pipe_hold = 1'b0;
`endif
            w_rf_valE   = c_ZERO;
            w_rf_valM   = c_ZERO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_RESET_STATE;
            r_starve     <= 4'd0;
`ifdef RF_CLEAR_ON_RESET_EN
            r_idx        <= 4'd0;
            r_clear_done <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_starve     <= w_starve_nxt;
`ifdef RF_CLEAR_ON_RESET_EN
            r_idx        <= w_idx_nxt;
            r_clear_done <= w_clear_done_nxt;
`endif
        end
    end

    assign bus.dbg_ready = w_ready;
    assign bus.rf_dstE   = w_rf_dstE;
    assign bus.rf_dstM   = w_rf_dstM;
    assign bus.rf_valE   = w_rf_valE;
    assign bus.rf_valM   = w_rf_valM;
    assign bus.pipe_hold = w_pipe_hold;
`ifdef RF_CLEAR_ON_RESET_EN
    assign bus.clear_done = r_clear_done && !reset;
`else
    assign bus.clear_done = 1'b1;
`endif

endmodule
`default_nettype wire
